// File: rtl/imm_pkg.sv
// Shared immediate-encoding constants and the compressor state type.
package imm_pkg;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned CHUNK_W    = 7;
   localparam int unsigned MAX_CHUNKS = (DATA_W + CHUNK_W - 1) / CHUNK_W;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

endpackage

// File: rtl/imm_fit_check.sv
// Finds the fewest CHUNK_W-bit chunks that rebuild in_data exactly under
// sign extension of the first chunk.
module imm_fit_check #(
   parameter int unsigned DATA_W  = imm_pkg::DATA_W,
   parameter int unsigned CHUNK_W = imm_pkg::CHUNK_W
) (
   input  logic [DATA_W-1:0] in_data,
   output logic [1:0]        n
);

   localparam int unsigned MAX_CHUNKS = (DATA_W + CHUNK_W - 1) / CHUNK_W;

   // Value fits in k chunks when every bit at or above k*CHUNK_W-1 equals the sign.
   function automatic logic fits(input logic [DATA_W-1:0] d, input int k);
      logic signed [DATA_W-1:0] top;
      top = $signed(d) >>> (k * int'(CHUNK_W) - 1);
      return (top == '0) || (top == '1);
   endfunction

   always_comb begin
      n = 2'(MAX_CHUNKS);
      for (int k = int'(MAX_CHUNKS) - 1; k >= 1; k--) begin
         if (fits(in_data, k)) n = 2'(k);
      end
   end

endmodule

// File: rtl/imm_compress.sv
// Splits a signed word into the minimum number of chunks, MS chunk first.
// Optional chunk handshake counter: define IMM_COMPRESS_CNT_EN.
module imm_compress #(
   parameter int unsigned DATA_W  = imm_pkg::DATA_W,
   parameter int unsigned CHUNK_W = imm_pkg::CHUNK_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [CHUNK_W-1:0] out_chunk,
   output logic               out_last,
   output logic [1:0]         out_idx,
   input  logic               out_ready
`ifdef IMM_COMPRESS_CNT_EN
   ,
   output logic [15:0]        chunk_cnt
`endif
);

   localparam int unsigned MAX_CHUNKS = (DATA_W + CHUNK_W - 1) / CHUNK_W;
   localparam int unsigned EXT_W      = MAX_CHUNKS * CHUNK_W;

   imm_pkg::state_t  state;
   imm_pkg::state_t  state_nxt;
   logic [EXT_W-1:0] ext_in;
   logic [EXT_W-1:0] word_q;
   logic [1:0]       n_q;
   logic [1:0]       n_fit;
   logic [1:0]       idx_nxt;
   logic             in_hs;
   logic             out_hs;

   // Chunk idx of an n-chunk word, counted from the most-significant end.
   function automatic logic [CHUNK_W-1:0] pick(input logic [EXT_W-1:0] w,
                                                input logic [1:0]       n,
                                                input logic [1:0]       idx);
      return CHUNK_W'(w >> ((int'(n) - 1 - int'(idx)) * int'(CHUNK_W)));
   endfunction

   imm_fit_check #(
      .DATA_W  (DATA_W),
      .CHUNK_W (CHUNK_W)
   ) u_fit (
      .in_data (in_data),
      .n       (n_fit)
   );

   assign ext_in  = EXT_W'($signed(in_data));
   assign in_hs   = in_valid & in_ready;
   assign out_hs  = out_valid & out_ready;
   assign idx_nxt = out_idx + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= imm_pkg::IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         imm_pkg::IDLE: if (in_valid)              state_nxt = imm_pkg::EMIT;
         imm_pkg::EMIT: if (out_ready && out_last) state_nxt = imm_pkg::IDLE;
         default:                                  state_nxt = imm_pkg::IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == imm_pkg::IDLE);
      out_valid = (state == imm_pkg::EMIT);
   end

   // Word capture and chunk presentation; chunk fields only move on a handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q    <= '0;
         n_q       <= 2'd1;
         out_chunk <= '0;
         out_idx   <= 2'd0;
         out_last  <= 1'b0;
      end else if (in_hs) begin
         word_q    <= ext_in;
         n_q       <= n_fit;
         out_chunk <= pick(ext_in, n_fit, 2'd0);
         out_idx   <= 2'd0;
         out_last  <= (n_fit == 2'd1);
      end else if (out_hs) begin
         if (!out_last) begin
            out_chunk <= pick(word_q, n_q, idx_nxt);
            out_idx   <= idx_nxt;
            out_last  <= (idx_nxt == n_q - 2'd1);
         end else begin
            out_chunk <= '0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
         end
      end
   end

`ifdef IMM_COMPRESS_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      chunk_cnt <= 16'd0;
      else if (out_hs) chunk_cnt <= chunk_cnt + 16'd1;
   end
`else
   // Handshake counter not built.
`endif

endmodule

// File: doc/imm_compress.md
IMM_COMPRESS -- requirements
Module: imm_compress

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of the signed input word.
REQ-002 The block SHALL have parameter CHUNK_W, default 7, giving the width of each emitted immediate chunk; MAX_CHUNKS SHALL equal ceil(DATA_W/CHUNK_W), which is 3 at defaults.
REQ-003 One clock and reset: `clk` is the single rising-edge clock; `rst_n` is an asynchronous, active-low reset.
REQ-004 Port `clk`: input, 1 bit, the system clock.
REQ-005 Port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-006 Port `in_valid`: input, 1 bit, asserted when `in_data` holds a word to compress.
REQ-007 Port `in_data`: input, DATA_W bits, the signed two's-complement word to compress.
REQ-008 Port `in_ready`: output, 1 bit, asserted when the block can accept a word.
REQ-009 Port `out_valid`: output, 1 bit, asserted when `out_chunk` holds a valid chunk.
REQ-010 Port `out_chunk`: output, CHUNK_W bits, the current chunk, emitted most-significant chunk first.
REQ-011 Port `out_last`: output, 1 bit, marks the final chunk of a word.
REQ-012 Port `out_idx`: output, 2 bits, the position of the current chunk within the word, starting at 0.
REQ-013 Port `out_ready`: input, 1 bit, asserted when the consumer accepts the current chunk.

Function
REQ-014 Compression SHALL be the inverse of 7-to-16 sign extension: the consumer rebuilds the word as acc = sext(c0), then acc = (acc << CHUNK_W) | ci for each following chunk ci, and the result SHALL equal `in_data` exactly.
REQ-015 Chunk count n SHALL be the minimum that allows exact reconstruction:
- n = 1 for values in [-64, 63];
- n = 2 for values in [-8192, 8191];
- n = 3 otherwise.
REQ-016 For n = 3 the chunks SHALL be c0 = sext7(in_data[15:14]), c1 = in_data[13:7], c2 = in_data[6:0].
REQ-017 For n = 2 the chunks SHALL be c0 = in_data[13:7], c1 = in_data[6:0]; for n = 1 the single chunk SHALL be c0 = in_data[6:0].
REQ-018 The state machine SHALL have two states, IDLE and EMIT.
REQ-019 `in_ready` SHALL equal (state == IDLE).
REQ-020 An input handshake (in_valid & in_ready) SHALL register the word and n, and move the state to EMIT.
REQ-021 `out_valid` SHALL be asserted in the cycle after acceptance, so input-to-first-chunk latency is 1 cycle.
REQ-022 In EMIT, `out_valid` SHALL be 1, and `out_chunk`, `out_idx` and `out_last` SHALL be registered and held stable while out_ready = 0.
REQ-023 On an output handshake with out_last = 0, `out_idx` SHALL increment and the next chunk SHALL be presented in the following cycle.
REQ-024 On an output handshake with out_last = 1, the state SHALL return to IDLE; peak throughput is therefore one word per n+1 cycles.
REQ-025 `out_last` SHALL be 1 exactly when out_idx == n-1.
REQ-026 Changes to `in_data` while in EMIT SHALL have no effect on the word being emitted.

Reset
REQ-027 Asserting rst_n = 0 SHALL, asynchronously and at any time including mid-word, set the state to IDLE with out_valid = 0, out_chunk = 0, out_idx = 0 and out_last = 0; `in_ready` SHALL then read 1.
REQ-028 A word that is partially emitted when reset asserts SHALL be discarded, and no chunk of it SHALL appear after reset is released.

Configuration
REQ-029 When macro IMM_COMPRESS_CNT_EN is defined, the block SHALL add output port `chunk_cnt` (output, 16 bits).
- `chunk_cnt` SHALL increment on every output handshake.
- It SHALL wrap from 0xFFFF to 0x0000.
- It SHALL be reset to 0 by rst_n.
REQ-030 When IMM_COMPRESS_CNT_EN is undefined, the `chunk_cnt` port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package imm_pkg SHALL hold DATA_W, CHUNK_W, MAX_CHUNKS and the state enum {IDLE, EMIT}, shared with the existing sign-extension logic.
REQ-032 The fit test SHALL be a separate combinational sub-module, imm_fit_check: input in_data, output n (2 bits).

Verification
REQ-033 Input 0x0005 -> a single chunk 0x05, idx 0, last = 1; in_ready returns high on the next cycle.
REQ-034 Input 0xFFC0 (-64) -> 0x40 (last). Input 0x0040 (+64) -> 0x00, then 0x40 (last).
REQ-035 Input 0x2000 -> 0x00, 0x40, 0x00 (last). Input 0x8000 -> 0x7E, 0x00, 0x00 (last).
REQ-036 Input 0x1234 with out_ready held low for 3 cycles on each chunk -> 0x24, then 0x34 (last); each chunk stays stable while stalled; in_ready stays 0 until the last handshake.
REQ-037 Assert rst_n low after the first chunk of 0x8000 -> out_valid = 0 immediately, with no remaining chunks; a following input 0x0001 -> 0x01 (last).
REQ-038 Random 10k words with random backpressure -> the reconstructed value equals the input and n is minimal; with IMM_COMPRESS_CNT_EN defined, chunk_cnt equals the total number of handshakes.
